fp_operand_stage: RTL and testbench
===================================

FP_OPERAND_STAGE -- requirements
Module: fp_operand_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  producer presents an operand pair.
REQ-005 in_ready  out  1  stage accepts the pair; transfer when in_valid && in_ready.
REQ-006 in_a, in_b  in  32 each  IEEE-754 single-precision operands.
REQ-007 out_valid  out  1  prepared pair available to the downstream fp adder.
REQ-008 out_ready  in  1  adder consumes; transfer when out_valid && out_ready.
REQ-009 out_x  out  32  larger-magnitude operand, after flush.
REQ-010 out_y  out  32  smaller-magnitude operand, after flush.
REQ-011 out_shift  out  5  alignment shift = Ex - Ey, saturated at 24.
REQ-012 out_sub  out  1  1 when the sign of out_x differs from the sign of out_y (effective subtract).
REQ-013 out_class  out  2  00 normal, 01 zero operand, 10 inf/NaN present, 11 exact cancellation.
REQ-014 op_count  out  16  count of output transfers.

Function
REQ-015 An operand with exponent 0 SHALL be flushed to signed zero: the sign is kept and bits [30:0] are forced to 0 before any comparison or output.
REQ-016 Magnitude compare SHALL use flushed bits [30:0] as an unsigned value; the larger goes to out_x; on a tie, in_a goes to out_x.
REQ-017 out_shift SHALL be min(Ex - Ey, 24) using the 8-bit biased exponents.
REQ-018 out_class priority SHALL be: 10 if either exponent is 0xFF; else 11 if magnitudes are equal and signs differ; else 01 if either flushed operand is zero; else 00.
REQ-019 Latency SHALL be 1 cycle: a pair accepted at edge N is presented with out_valid=1 after edge N.
REQ-020 While out_valid && !out_ready, all out_* signals SHALL be held stable.
REQ-021 Outputs SHALL be delivered in acceptance order, with no loss or duplication.
REQ-022 Sustained throughput SHALL be 1 pair per cycle while out_ready=1.
REQ-023 op_count SHALL increment on each output transfer and wrap from 0xFFFF to 0x0000.
REQ-024 A simultaneous accept and output transfer in one cycle SHALL be legal and SHALL leave occupancy unchanged.

Reset
REQ-025 While rst=1: out_valid=0, in_ready=0, out_x=out_y=0, out_shift=0, out_sub=0, out_class=00, op_count=0.
REQ-026 A reset asserted mid-operation SHALL discard all buffered pairs with no output transfer and no count increment.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 FP_OPSTAGE_SKID_EN defined: a 2-entry skid buffer; in_ready is registered and equals (occupancy < 2); up to 2 pairs are accepted while out_ready=0.
REQ-029 FP_OPSTAGE_SKID_EN undefined: a single output register; in_ready = !rst && (!out_valid || out_ready), combinational; at most 1 pair is held.
REQ-030 Functional results and ordering SHALL be identical in both configurations.

Verification
REQ-031 Normal pair: a=0x3F800000, b=0x40000000 -> next cycle out_x=0x40000000, out_y=0x3F800000, out_shift=1, out_sub=0, out_class=00.
REQ-032 Cancellation and tie: a=0x40400000, b=0xC0400000 -> out_x=0x40400000, out_y=0xC0400000, out_sub=1, out_class=11, out_shift=0.
REQ-033 Special and flush cases:
- a=0x7F800000, b=0x3F800000 -> out_class=10.
- a=0x00000001, b=0x3F800000 -> out_x=0x3F800000, out_y=0x00000000, out_class=01.
REQ-034 Shift saturation: a=0x4F800000, b=0x3F800000 -> out_shift=24, out_x=0x4F800000.
REQ-035 Backpressure: hold out_ready=0 for 4 cycles with in_valid=1 and 3 distinct pairs queued ->
- SKID_EN: 2 pairs accepted, then in_ready=0.
- Otherwise: 1 pair accepted.
- In both: outputs stable while stalled; after out_ready=1, all 3 pairs emerge in order and op_count=3.
REQ-036 Reset mid-stall with 2 pairs held (SKID_EN) -> out_valid=0 and op_count=0 the cycle after rst; the old pairs never appear.

Source files
------------

// File: rtl/fp_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fp_operand_stage
//  Description : Operand preparation stage for a single-precision fp adder.
//                Flushes denormals to signed zero, orders the pair by
//                magnitude, computes the saturated alignment shift, the
//                effective-subtract flag and a coarse operand class, and
//                hands the prepared pair downstream over valid/ready.
//                Build option FP_OPSTAGE_SKID_EN selects a 2-entry skid
//                buffer with a registered in_ready; otherwise a single
//                output register with a combinational in_ready is used.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_operand_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_x,
   output logic [31:0] out_y,
   output logic [4:0]  out_shift,
   output logic        out_sub,
   output logic [1:0]  out_class,
   output logic [15:0] op_count
);

   localparam logic [7:0] EXP_MAX   = 8'hFF;
   localparam logic [7:0] SHIFT_SAT = 8'd24;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [4:0]  shift;
      logic        sub;
      logic [1:0]  cls;
   } prep_t;

   prep_t       prep;
   prep_t       head;
   logic [31:0] fa;
   logic [31:0] fb;
   logic        a_ge;
   logic [7:0]  ediff;
   logic        push;
   logic        pop;

   // Flush, order by magnitude and classify the incoming pair
   always_comb begin
      fa         = (in_a[30:23] == 8'h00) ? {in_a[31], 31'd0} : in_a;
      fb         = (in_b[30:23] == 8'h00) ? {in_b[31], 31'd0} : in_b;
      // Ties keep in_a as the larger operand
      a_ge       = (fa[30:0] >= fb[30:0]);
      prep.x     = a_ge ? fa : fb;
      prep.y     = a_ge ? fb : fa;
      // x has the larger magnitude, so its exponent is never below y's
      ediff      = prep.x[30:23] - prep.y[30:23];
      prep.shift = (ediff > SHIFT_SAT) ? 5'd24 : ediff[4:0];
      prep.sub   = prep.x[31] ^ prep.y[31];
      if ((in_a[30:23] == EXP_MAX) || (in_b[30:23] == EXP_MAX))
         prep.cls = 2'b10;
      else if ((fa[30:0] == fb[30:0]) && (fa[31] != fb[31]))
         prep.cls = 2'b11;
      else if ((fa[30:0] == 31'd0) || (fb[30:0] == 31'd0))
         prep.cls = 2'b01;
      else
         prep.cls = 2'b00;
   end

   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_x     = head.x;
   assign out_y     = head.y;
   assign out_shift = head.shift;
   assign out_sub   = head.sub;
   assign out_class = head.cls;

`ifdef FP_OPSTAGE_SKID_EN
   logic [1:0] count;
   logic [1:0] count_nxt;
   logic       not_full;
   prep_t      skid;

   // Occupancy after this cycle's accept/consume
   always_comb begin
      count_nxt = count + {1'b0, push} - {1'b0, pop};
   end

   // Two-entry buffer: head drives the outputs, skid holds the overflow pair
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= 2'd0;
         not_full <= 1'b1;
         head     <= '0;
         skid     <= '0;
      end else begin
         count    <= count_nxt;
         not_full <= (count_nxt < 2'd2);
         if (pop && (count == 2'd2))
            head <= skid;
         else if (push && ((count == 2'd0) || pop))
            head <= prep;
         else if (push)
            skid <= prep;
      end
   end

   assign in_ready  = !rst && not_full;
   assign out_valid = (count != 2'd0);
`else
   logic valid_q;

   // Single output register, reloadable in the same cycle it is consumed
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         head    <= '0;
      end else if (push) begin
         valid_q <= 1'b1;
         head    <= prep;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign in_ready  = !rst && (!valid_q || out_ready);
   assign out_valid = valid_q;
`endif

   // Count of output transfers, wrapping naturally at 16 bits
   always_ff @(posedge clk) begin
      if (rst)
         op_count <= 16'd0;
      else if (pop)
         op_count <= op_count + 16'd1;
   end

endmodule
`default_nettype wire

// File: tb/tb_fp_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_operand_stage
//  Description : Scoreboard bench for fp_operand_stage with a behavioural
//                reference model and randomized operand pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_operand_stage;

`ifdef FP_OPSTAGE_SKID_EN
   localparam int EXP_BP = 2;
`else
   localparam int EXP_BP = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_x;
   logic [31:0] out_y;
   logic [4:0]  out_shift;
   logic        out_sub;
   logic [1:0]  out_class;
   logic [15:0] op_count;

   fp_operand_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_y     (out_y),
      .out_shift (out_shift),
      .out_sub   (out_sub),
      .out_class (out_class),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      int          shift;
      int          sub;
      int          cls;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] pend_a[$];
   logic [31:0] pend_b[$];
   int          checks = 0;
   int          errors = 0;
   int          accepted = 0;
   bit          rand_ready = 0;
   logic [15:0] exp_cnt = '0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Reference model computed directly from the operand rules
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      int unsigned ea, eb, ma, mb;
      logic [31:0] fa, fb;
      int          d;
      ea = (a >> 23) & 32'hFF;
      eb = (b >> 23) & 32'hFF;
      fa = (ea == 0) ? (a & 32'h8000_0000) : a;
      fb = (eb == 0) ? (b & 32'h8000_0000) : b;
      ma = fa & 32'h7FFF_FFFF;
      mb = fb & 32'h7FFF_FFFF;
      if (ma >= mb) begin e.x = fa; e.y = fb; end
      else          begin e.x = fb; e.y = fa; end
      d = int'((e.x >> 23) & 32'hFF) - int'((e.y >> 23) & 32'hFF);
      e.shift = (d > 24) ? 24 : d;
      e.sub   = (e.x[31] != e.y[31]) ? 1 : 0;
      if (ea == 255 || eb == 255)                e.cls = 2;
      else if (ma == mb && fa[31] != fb[31])     e.cls = 3;
      else if (ma == 0 || mb == 0)               e.cls = 1;
      else                                       e.cls = 0;
      return e;
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [7:0] e;
      int k = $urandom_range(0, 9);
      case (k)
         0:       e = 8'h00;
         1:       e = 8'hFF;
         2:       e = 8'd127;
         default: e = 8'($urandom);
      endcase
      return {1'($urandom), e, (k == 3) ? 23'd0 : 23'($urandom)};
   endfunction

   task automatic add_pair(input logic [31:0] a, input logic [31:0] b);
      pend_a.push_back(a);
      pend_b.push_back(b);
   endtask

   task automatic add_random_pair();
      logic [31:0] a = rnd_fp();
      logic [31:0] b;
      case ($urandom_range(0, 5))
         0:       b = a ^ 32'h8000_0000;
         1:       b = a;
         2:       b = {a[31:23] + 9'($urandom_range(0, 3)), 23'($urandom)};
         default: b = rnd_fp();
      endcase
      add_pair(a, b);
   endtask

   task automatic present();
      if (pend_a.size() > 0) begin
         in_valid = 1'b1;
         in_a     = pend_a[0];
         in_b     = pend_b[0];
      end else begin
         in_valid = 1'b0;
      end
      if (rand_ready && ($urandom_range(0, 4) == 0)) in_valid = 1'b0;
   endtask

   // One clock: record an acceptance, then drive the next cycle's inputs
   task automatic step();
      @(negedge clk);
      if (in_valid && in_ready && !rst) begin
         sb.push_back(model(in_a, in_b));
         accepted++;
         void'(pend_a.pop_front());
         void'(pend_b.pop_front());
      end
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      present();
   endtask

   task automatic drain();
      int n = 0;
      while ((pend_a.size() > 0 || sb.size() > 0) && n < 5000) begin
         step();
         n++;
      end
      checks++;
      if (n >= 5000) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size() + pend_a.size());
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      pend_a.delete();
      pend_b.delete();
      @(posedge clk);
      #1;
      chk("rst_out_valid", 72'(out_valid), 72'(0));
      chk("rst_in_ready",  72'(in_ready),  72'(0));
      chk("rst_outputs",   {out_x, out_y, out_shift, out_sub, out_class}, 72'(0));
      chk("rst_op_count",  72'(op_count),  72'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 72'(in_ready), 72'(1));
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops and compares on every output transfer, checks stalls
   initial begin
      logic [71:0] cur;
      logic [71:0] held;
      bit          stalled = 0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            exp_cnt = '0;
            stalled = 0;
         end else begin
            chk("op_count", 72'(op_count), 72'(exp_cnt));
            cur = {out_x, out_y, out_shift, out_sub, out_class};
            if (stalled) begin
               chk("stall_valid", 72'(out_valid), 72'(1));
               chk("stall_stable", cur, held);
            end
            if (out_valid && out_ready) begin
               stalled = 0;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got %h expected none", cur);
               end else begin
                  e = sb.pop_front();
                  chk("out_x",     72'(out_x),     72'(e.x));
                  chk("out_y",     72'(out_y),     72'(e.y));
                  chk("out_shift", 72'(out_shift), 72'(e.shift));
                  chk("out_sub",   72'(out_sub),   72'(e.sub));
                  chk("out_class", 72'(out_class), 72'(e.cls));
               end
               exp_cnt = exp_cnt + 16'd1;
            end else if (out_valid) begin
               held    = cur;
               stalled = 1;
            end else begin
               stalled = 0;
            end
         end
      end
   end

   initial begin
      int a0;
      int n_wrap;
      do_reset();

      // Directed pairs: normal, cancellation/tie, inf, denormal flush, saturation
      add_pair(32'h3F80_0000, 32'h4000_0000);
      add_pair(32'h4040_0000, 32'hC040_0000);
      add_pair(32'h7F80_0000, 32'h3F80_0000);
      add_pair(32'h0000_0001, 32'h3F80_0000);
      add_pair(32'h4F80_0000, 32'h3F80_0000);
      add_pair(32'h8000_0000, 32'h0000_0000);
      present();
      drain();

      // Backpressure: three pairs offered while the consumer stalls
      do_reset();
      out_ready = 1'b0;
      add_pair(32'h3F80_0000, 32'h4000_0000);
      add_pair(32'hC0A0_0000, 32'h4120_0000);
      add_pair(32'h4040_0000, 32'hC040_0000);
      present();
      a0 = accepted;
      repeat (4) step();
      chk("bp_accepted", 72'(accepted - a0), 72'(EXP_BP));
      chk("bp_in_ready", 72'(in_ready), 72'(0));
      out_ready = 1'b1;
      drain();
      step();
      chk("bp_op_count", 72'(op_count), 72'(3));

      // Reset while pairs are held: nothing old may emerge afterwards
      out_ready = 1'b0;
      add_pair(32'h4100_0000, 32'h3F80_0000);
      add_pair(32'h4200_0000, 32'h3F80_0000);
      present();
      repeat (4) step();
      rst      = 1'b1;
      in_valid = 1'b0;
      pend_a.delete();
      pend_b.delete();
      @(posedge clk);
      #1;
      chk("midrst_out_valid", 72'(out_valid), 72'(0));
      chk("midrst_op_count",  72'(op_count),  72'(0));
      rst       = 1'b0;
      out_ready = 1'b1;
      repeat (6) step();

      // Sustained throughput with the consumer always ready
      for (int i = 0; i < 8; i++) add_random_pair();
      present();
      a0 = accepted;
      repeat (8) step();
      chk("throughput", 72'(accepted - a0), 72'(8));
      drain();

      // Randomized traffic with random backpressure and bubbles
      rand_ready = 1;
      for (int i = 0; i < 400; i++) add_random_pair();
      present();
      drain();
      rand_ready = 0;
      out_ready  = 1'b1;
      repeat (3) step();

      // Long stream to carry op_count through its wrap
      do_reset();
      n_wrap = 65540;
      for (int i = 0; i < n_wrap; i++) begin
         add_random_pair();
         if (i == 0) present();
         step();
      end
      drain();
      step();
      chk("wrap_op_count", 72'(op_count), 72'(16'(n_wrap)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
